// File: rtl/seq_alu.sv
// Multi-cycle unsigned ALU: add/sub in one cycle, shift-add multiply and restoring divide over WIDTH cycles.
// Optional `SEQ_ALU_FLAGS_EN` adds registered zero and signed-overflow flags.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 cin,
    input  logic [1:0]           sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 carry
`ifdef SEQ_ALU_FLAGS_EN
    ,
    output logic                 zero,
    output logic                 ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opnd;     // multiplicand for mul, divisor for div
    logic [WIDTH-1:0] hi;       // partial-product high half / partial remainder
    logic [WIDTH-1:0] lo;       // multiplier bits / dividend-then-quotient bits

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;
    logic             last_iter;

    assign add_sum  = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
    assign sub_diff = {1'b0, a} - {1'b0, b};

    assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    assign div_shift = {hi, lo[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opnd};
    assign div_ge    = ~div_diff[WIDTH+1];

    assign last_iter = (cnt == CW'(WIDTH-1));

    // NOTE: always_comb gives every output a default first so no latch can be inferred.
    always_comb begin
        hi_n = hi;
        lo_n = lo;
        if (state == MUL) begin
            hi_n = mul_sum[WIDTH:1];
            lo_n = {mul_sum[0], lo[WIDTH-1:1]};
        end else if (state == DIV) begin
            hi_n = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], div_ge};
        end
    end

    // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            opnd      <= '0;
            hi        <= '0;
            lo        <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
`ifdef SEQ_ALU_FLAGS_EN
            zero      <= 1'b0;
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    in_ready <= 1'b0;
                    cnt      <= '0;
                    case (sel)
                        2'b00: begin
                            result    <= {{WIDTH{1'b0}}, add_sum[WIDTH-1:0]};
                            carry     <= add_sum[WIDTH];
                            out_valid <= 1'b1;
                            state     <= DONE;
`ifdef SEQ_ALU_FLAGS_EN
                            zero <= ~|add_sum[WIDTH-1:0];
                            ovf  <= (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
`endif
                        end
                        2'b01: begin
                            result    <= {{WIDTH{1'b0}}, sub_diff[WIDTH-1:0]};
                            carry     <= ~sub_diff[WIDTH];
                            out_valid <= 1'b1;
                            state     <= DONE;
`ifdef SEQ_ALU_FLAGS_EN
                            zero <= ~|sub_diff[WIDTH-1:0];
                            ovf  <= (a[WIDTH-1] != b[WIDTH-1]) && (sub_diff[WIDTH-1] != a[WIDTH-1]);
`endif
                        end
                        2'b10: begin
                            opnd  <= a;
                            hi    <= '0;
                            lo    <= b;
                            state <= MUL;
                        end
                        default: begin
                            opnd  <= b;
                            hi    <= '0;
                            lo    <= a;
                            state <= DIV;
                        end
                    endcase
                end
                MUL, DIV: begin
                    hi  <= hi_n;
                    lo  <= lo_n;
                    cnt <= cnt + CW'(1);
                    if (last_iter) begin
                        result    <= {hi_n, lo_n};
                        // mul flags a non-zero high half; div flags a zero divisor
                        carry     <= (state == MUL) ? |hi_n : (opnd == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef SEQ_ALU_FLAGS_EN
                        zero <= ~|{hi_n, lo_n};
                        ovf  <= 1'b0;
`endif
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
